// File: rtl/jk_modulo_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_modulo_updown_counter
//
// Synchronous modulo up/down counter built from JK-style bit cells that all
// share one clock. Each bit computes its own J/K pair from the mode and the
// state of the bits below it: toggle (J=K=1) for counting, set/reset
// (J=d, K=~d) for parallel load and for the modulo wrap, J=K=0 to hold.
//
// Parameters
//   WIDTH    number of count bits (>= 1)
//   MODULUS  count range 0..MODULUS-1, legal range 2..2**WIDTH
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   enable      count enable; when low the counter holds and pulses clear
//   mode        00 hold, 01 down, 10 up, 11 load
//   load_value  parallel load data, clamped to MODULUS-1
//   count       registered count value
//   terminal    combinational: next enabled edge will wrap
//   carry_out   registered one-cycle pulse on an up-wrap
//   borrow_out  registered one-cycle pulse on a down-wrap
// ---------------------------------------------------------------------------
module jk_modulo_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             carry_out,
    output logic             borrow_out
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    // With a power-of-two modulus the plain toggle chain already wraps
    // 2**WIDTH-1 -> 0 and 0 -> 2**WIDTH-1, so no wrap override is needed.
    localparam bit FULL_RANGE = (longint'(MODULUS) == (longint'(1) << WIDTH));

    generate
        if (WIDTH < 1 || MODULUS < 2 ||
            longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
            $fatal(1, "jk_modulo_updown_counter: illegal WIDTH/MODULUS");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic             carry_q;
    logic             borrow_q;

    logic [WIDTH-1:0] up_toggle;
    logic [WIDTH-1:0] down_toggle;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_max;
    logic             at_zero;
    logic             up_wrap;
    logic             down_wrap;

    // Bit i toggles counting up when every lower bit is 1, and counting down
    // when every lower bit is 0. Bit 0 always toggles.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_toggle
            if (gi == 0) begin : g_lsb
                assign up_toggle[gi]   = 1'b1;
                assign down_toggle[gi] = 1'b1;
            end else begin : g_upper
                assign up_toggle[gi]   = &count_q[gi-1:0];
                assign down_toggle[gi] = ~(|count_q[gi-1:0]);
            end
        end
    endgenerate

    assign at_max       = (count_q == MAX_COUNT);
    assign at_zero      = (count_q == '0);
    assign up_wrap      = enable && (mode == MODE_UP)   && at_max;
    assign down_wrap    = enable && (mode == MODE_DOWN) && at_zero;
    assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

    always_comb begin
        j = '0;
        k = '0;
        if (enable) begin
            case (mode)
                MODE_UP: begin
                    if (!FULL_RANGE && at_max) begin
                        j = '0;
                        k = '1;
                    end else begin
                        j = up_toggle;
                        k = up_toggle;
                    end
                end
                MODE_DOWN: begin
                    if (!FULL_RANGE && at_zero) begin
                        j = MAX_COUNT;
                        k = ~MAX_COUNT;
                    end else begin
                        j = down_toggle;
                        k = down_toggle;
                    end
                end
                MODE_LOAD: begin
                    j = load_clamped;
                    k = ~load_clamped;
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    // Characteristic JK equation applied to every bit in parallel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= (j & ~count_q) | (~k & count_q);
            carry_q  <= up_wrap;
            borrow_q <= down_wrap;
        end
    end

    assign count      = count_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;

    // Gated by reset so the flag stays low while held in reset even though
    // count=0 would otherwise match the down-wrap condition.
    assign terminal = reset && (up_wrap || down_wrap);

endmodule
